// File: rtl/apb_master_mux.sv
// rtl/apb_master_mux.sv - APB3 requester bridge with built-in address decode, response mux and error reporting
// Optional feature macro: APB_TIMEOUT_EN (aborts ACCESS after TIMEOUT cycles without PREADY)
module apb_master_mux #(
    parameter int          NUM_SLAVES  = 5,
    parameter int          DATA_W      = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          REGION_BITS = 12,
    parameter int          TIMEOUT     = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         transfer,
    input  logic                         write,
    input  logic [31:0]                  addr,
    input  logic [DATA_W-1:0]            wdata,
    output logic                         ready,
    output logic [DATA_W-1:0]            rdata,
    output logic                         slverr,
    output logic [31:0]                  PADDR,
    output logic                         PWRITE,
    output logic                         PENABLE,
    output logic [DATA_W-1:0]            PWDATA,
    output logic [NUM_SLAVES-1:0]        PSEL,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              idx_q, idx_d;
    logic [31:0]             paddr_d;
    logic                    pwrite_d;
    logic                    penable_d;
    logic [DATA_W-1:0]       pwdata_d;
    logic [NUM_SLAVES-1:0]   psel_d;
    logic                    ready_d;
    logic                    slverr_d;
    logic [DATA_W-1:0]       rdata_d;

    logic [3:0]              req_idx;
    logic                    req_hit;
    logic                    pready_sel;
    logic                    pslverr_sel;
    logic [DATA_W-1:0]       prdata_sel;

`ifdef APB_TIMEOUT_EN
    logic [7:0]              cnt_q, cnt_d;
`else
    logic                    unused_timeout;
    assign unused_timeout = ^8'(TIMEOUT);
`endif

    // Region decode: slave index from the region field, upper bits must match the window
    assign req_idx = addr[REGION_BITS+3:REGION_BITS];
    assign req_hit = ({1'b0, req_idx} < 5'(NUM_SLAVES)) &&
                     (addr[31:REGION_BITS+4] == BASE_ADDR[31:REGION_BITS+4]);

    // Response mux: only the latched slave's ready/error/data are looked at
    always_comb begin
        pready_sel  = 1'b0;
        pslverr_sel = 1'b0;
        prdata_sel  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == 4'(i)) begin
                pready_sel  = PREADY[i];
                pslverr_sel = PSLVERR[i];
                prdata_sel  = PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next-output logic; every output is registered
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        paddr_d   = PADDR;
        pwrite_d  = PWRITE;
        pwdata_d  = PWDATA;
        penable_d = PENABLE;
        psel_d    = PSEL;
        ready_d   = 1'b0;
        slverr_d  = slverr;
        rdata_d   = rdata;
`ifdef APB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    paddr_d  = addr;
                    pwrite_d = write;
                    pwdata_d = wdata;
                    if (req_hit) begin
                        state_d = SETUP;
                        idx_d   = req_idx;
                        for (int i = 0; i < NUM_SLAVES; i++) begin
                            psel_d[i] = (req_idx == 4'(i));
                        end
                    end else begin
                        state_d  = RESP;
                        ready_d  = 1'b1;
                        slverr_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: begin
                if (pready_sel) begin
                    state_d   = RESP;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    ready_d   = 1'b1;
                    slverr_d  = pslverr_sel;
                    if (!PWRITE) begin
                        rdata_d = prdata_sel;
                    end
                end
`ifdef APB_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d   = RESP;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    ready_d   = 1'b1;
                    slverr_d  = 1'b1;
                    rdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the bus immediately
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
            idx_q   <= '0;
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            PWDATA  <= '0;
            PENABLE <= 1'b0;
            PSEL    <= '0;
            ready   <= 1'b0;
            slverr  <= 1'b0;
            rdata   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            PADDR   <= paddr_d;
            PWRITE  <= pwrite_d;
            PWDATA  <= pwdata_d;
            PENABLE <= penable_d;
            PSEL    <= psel_d;
            ready   <= ready_d;
            slverr  <= slverr_d;
            rdata   <= rdata_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    // ACCESS wait-cycle counter
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule
